sdram_mc_arbiter: RTL and testbench

//  Multi-channel single-clock front end for the sdram_ctrl internal interface (idle/acc/ack/we).

---
 rtl/sdram_mc_pkg.sv | 20 ++
 rtl/sdram_mc_arbiter_rr_arbiter.sv | 53 +++++
 rtl/sdram_mc_arbiter.sv | 150 +++++++++++++++
 tb/tb_sdram_mc_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_mc_pkg.sv
// Shared types and helpers for the sdram_ctrl multi-channel arbiter.
// Optional build macro SDRAM_MC_PRIO_EN (see rr_arbiter) gives channel 0 fixed priority.
package sdram_mc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        RSP      = 2'd3
    } state_t;

    // Channel-index width, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_CH_DEF = 2;
    localparam int CH_W       = ch_width(NUM_CH_DEF);

endpackage

// File: rtl/sdram_mc_arbiter_rr_arbiter.sv
// Combinational round-robin picker: request vector + pointer -> one-hot grant, index and next pointer.
// With SDRAM_MC_PRIO_EN defined, channel 0 wins whenever it requests and leaves the pointer untouched.
module rr_arbiter
    import sdram_mc_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_any,
    output logic [IDX_W-1:0]  next_ptr
);

`ifdef SDRAM_MC_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        next_ptr  = ptr;
        if (PRIO && req[0]) begin
            grant[0]  = 1'b1;
            grant_any = 1'b1;
        end else begin
            // Two passes: channels at/above the pointer first, then the wrapped ones below it.
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grant_any && req[i] && i >= int'(ptr)) begin
                    grant[i]  = 1'b1;
                    grant_any = 1'b1;
                    grant_idx = IDX_W'(i);
                    next_ptr  = IDX_W'((i + 1) % NUM_CH);
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grant_any && req[i] && i < int'(ptr)) begin
                    grant[i]  = 1'b1;
                    grant_any = 1'b1;
                    grant_idx = IDX_W'(i);
                    next_ptr  = IDX_W'((i + 1) % NUM_CH);
                end
            end
        end
    end

endmodule

// File: rtl/sdram_mc_arbiter.sv
// Multi-channel front end for the sdram_ctrl idle/acc/ack/we interface: round-robin command
// arbitration, single-word writes, 1..BURST_MAX word reads on a shared response port (SDRAM_MC_PRIO_EN optional).
module sdram_mc_arbiter
    import sdram_mc_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_MAX  = 8,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                                  sdram_clk,
    input  logic                                  sdram_rst,
    input  logic [NUM_CH-1:0]                     cmd_valid_i,
    output logic [NUM_CH-1:0]                     cmd_ready_o,
    input  logic [NUM_CH-1:0]                     cmd_we_i,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     cmd_data_i,
    input  logic [NUM_CH-1:0][LEN_WIDTH-1:0]      cmd_len_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0]                 rsp_data_o,
    output logic [ch_width(NUM_CH)-1:0]           rsp_ch_o,
    output logic                                  rsp_last_o,
    input  logic                                  sc_idle_i,
    output logic                                  sc_acc_o,
    output logic                                  sc_we_o,
    output logic [ADDR_WIDTH-1:0]                 sc_adr_o,
    output logic [DATA_WIDTH-1:0]                 sc_dat_o,
    input  logic [DATA_WIDTH-1:0]                 sc_dat_i,
    input  logic                                  sc_ack_i
);

    localparam int IDX_W = ch_width(NUM_CH);

    typedef struct packed {
        state_t                  state;
        logic [IDX_W-1:0]        rr_ptr;
        logic                    we;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   data;
        logic [IDX_W-1:0]        ch;
        logic [LEN_WIDTH-1:0]    remaining;
        logic                    sc_acc;
        logic                    sc_we;
        logic [ADDR_WIDTH-1:0]   sc_adr;
        logic [DATA_WIDTH-1:0]   sc_dat;
        logic                    rsp_valid;
        logic [DATA_WIDTH-1:0]   rsp_data;
        logic [IDX_W-1:0]        rsp_ch;
        logic                    rsp_last;
    } regs_t;

    regs_t r, r_d;

    logic [NUM_CH-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_any;
    logic [IDX_W-1:0]  next_ptr;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req       (cmd_valid_i),
        .ptr       (r.rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any),
        .next_ptr  (next_ptr)
    );

    // Out-of-range lengths (0 or above BURST_MAX) degrade to a single-word read.
    function automatic logic [LEN_WIDTH-1:0] burst_words(input logic [LEN_WIDTH-1:0] len);
        if (len == '0 || int'(len) > BURST_MAX)
            return LEN_WIDTH'(1);
        return len;
    endfunction

    always_comb begin
        r_d         = r;
        cmd_ready_o = '0;
        unique case (r.state)
            IDLE: begin
                if (grant_any && !sdram_rst) begin
                    cmd_ready_o   = grant;
                    r_d.we        = cmd_we_i[grant_idx];
                    r_d.addr      = cmd_addr_i[grant_idx];
                    r_d.data      = cmd_data_i[grant_idx];
                    r_d.ch        = grant_idx;
                    r_d.remaining = burst_words(cmd_len_i[grant_idx]);
                    r_d.rr_ptr    = next_ptr;
                    r_d.state     = ISSUE;
                end
            end
            ISSUE: begin
                if (sc_idle_i) begin
                    r_d.sc_acc = 1'b1;
                    r_d.sc_we  = r.we;
                    r_d.sc_adr = r.addr;
                    r_d.sc_dat = r.data;
                    r_d.state  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sc_ack_i) begin
                    r_d.sc_acc = 1'b0;
                    r_d.sc_we  = 1'b0;
                    if (r.we) begin
                        r_d.state = IDLE;
                    end else begin
                        r_d.rsp_valid = 1'b1;
                        r_d.rsp_data  = sc_dat_i;
                        r_d.rsp_ch    = r.ch;
                        r_d.rsp_last  = (r.remaining == LEN_WIDTH'(1));
                        r_d.state     = RSP;
                    end
                end
            end
            RSP: begin
                // The burst stays atomic: arbitration only resumes once the last word is taken.
                if (rsp_ready_i) begin
                    r_d.rsp_valid = 1'b0;
                    r_d.remaining = r.remaining - LEN_WIDTH'(1);
                    r_d.addr      = r.addr + ADDR_WIDTH'(1);
                    r_d.state     = (r.remaining == LEN_WIDTH'(1)) ? IDLE : ISSUE;
                end
            end
            default: r_d.state = IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (sdram_rst)
            r <= '0;
        else
            r <= r_d;
    end

    assign sc_acc_o    = r.sc_acc;
    assign sc_we_o     = r.sc_we;
    assign sc_adr_o    = r.sc_adr;
    assign sc_dat_o    = r.sc_dat;
    assign rsp_valid_o = r.rsp_valid;
    assign rsp_data_o  = r.rsp_data;
    assign rsp_ch_o    = r.rsp_ch;
    assign rsp_last_o  = r.rsp_last;

endmodule

// File: tb/tb_sdram_mc_arbiter.sv
// Scoreboard bench for sdram_mc_arbiter: accepted commands push expected sdram accesses and read
// words; an sdram_ctrl model and a response monitor pop and compare them independently.
module tb_sdram_mc_arbiter;

    localparam int NUM_CH    = 2;
    localparam int AW        = 24;
    localparam int DW        = 16;
    localparam int BURST_MAX = 8;
    localparam int LW        = 4;
    localparam int CW        = 1;

    logic                         sdram_clk = 1'b0;
    logic                         sdram_rst;
    logic [NUM_CH-1:0]            cmd_valid_i;
    logic [NUM_CH-1:0]            cmd_ready_o;
    logic [NUM_CH-1:0]            cmd_we_i;
    logic [NUM_CH-1:0][AW-1:0]    cmd_addr_i;
    logic [NUM_CH-1:0][DW-1:0]    cmd_data_i;
    logic [NUM_CH-1:0][LW-1:0]    cmd_len_i;
    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [DW-1:0]                rsp_data_o;
    logic [CW-1:0]                rsp_ch_o;
    logic                         rsp_last_o;
    logic                         sc_idle_i;
    logic                         sc_acc_o;
    logic                         sc_we_o;
    logic [AW-1:0]                sc_adr_o;
    logic [DW-1:0]                sc_dat_o;
    logic [DW-1:0]                sc_dat_i;
    logic                         sc_ack_i;

    always #5 sdram_clk = ~sdram_clk;

    sdram_mc_arbiter #(
        .NUM_CH     (NUM_CH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BURST_MAX),
        .LEN_WIDTH  (LW)
    ) dut (
        .sdram_clk   (sdram_clk),
        .sdram_rst   (sdram_rst),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_len_i   (cmd_len_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_ch_o    (rsp_ch_o),
        .rsp_last_o  (rsp_last_o),
        .sc_idle_i   (sc_idle_i),
        .sc_acc_o    (sc_acc_o),
        .sc_we_o     (sc_we_o),
        .sc_adr_o    (sc_adr_o),
        .sc_dat_o    (sc_dat_o),
        .sc_dat_i    (sc_dat_i),
        .sc_ack_i    (sc_ack_i)
    );

    typedef struct {
        logic [AW-1:0] adr;
        logic          we;
        logic [DW-1:0] dat;
    } acc_t;

    typedef struct {
        logic [DW-1:0] dat;
        logic [CW-1:0] ch;
        logic          last;
    } rsp_t;

    acc_t          acc_q[$];
    rsp_t          rsp_q[$];
    logic [DW-1:0] ref_mem[int];
    logic [DW-1:0] sd_mem[int];

    int n_vec = 0;
    int n_fail = 0;
    int ref_ptr = 0;
    int acc_count = 0;
    int block_idx = -1;
    int rdy_mode = 2;
    bit in_acc = 1'b0;
    int ack_delay = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Contents of never-written locations, shared by the sdram model and the reference memory.
    function automatic logic [DW-1:0] init_word(input int a);
        return DW'((a * 40503) ^ 32'h5A5A);
    endfunction

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Arbitration rule: first valid channel scanning upward from the pointer, wrapping.
    function automatic int exp_grant(input logic [NUM_CH-1:0] v);
`ifdef SDRAM_MC_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (ref_ptr + k) % NUM_CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Grant monitor: checks arbitration and pushes the expected accesses and read words.
    logic [NUM_CH-1:0] prev_ready = '0;
    always @(negedge sdram_clk) begin
        int g;
        int n;
        logic [AW-1:0] a;
        if (!sdram_rst) begin
            for (int c = 0; c < NUM_CH; c++)
                if (prev_ready[c]) check("ready_pulse", 64'(cmd_ready_o[c]), 64'd0);
            if (cmd_ready_o != '0) begin
                g = -1;
                for (int c = NUM_CH - 1; c >= 0; c--)
                    if (cmd_ready_o[c]) g = c;
                check("ready_onehot", 64'($countones(cmd_ready_o)), 64'd1);
                check("grant_ch", 64'(g), 64'(exp_grant(cmd_valid_i)));
                check("ready_needs_valid", 64'(cmd_valid_i[g]), 64'd1);
`ifdef SDRAM_MC_PRIO_EN
                if (g != 0) ref_ptr = (g + 1) % NUM_CH;
`else
                ref_ptr = (g + 1) % NUM_CH;
`endif
                a = cmd_addr_i[g];
                if (cmd_we_i[g]) begin
                    acc_q.push_back('{adr: a, we: 1'b1, dat: cmd_data_i[g]});
                    ref_mem[int'(a)] = cmd_data_i[g];
                end else begin
                    n = (cmd_len_i[g] == 0 || int'(cmd_len_i[g]) > BURST_MAX) ? 1 : int'(cmd_len_i[g]);
                    for (int i = 0; i < n; i++) begin
                        logic [AW-1:0] ai;
                        ai = a + AW'(i);
                        acc_q.push_back('{adr: ai, we: 1'b0, dat: '0});
                        rsp_q.push_back('{dat: ref_rd(int'(ai)), ch: CW'(g), last: (i == n - 1)});
                    end
                end
            end
        end
        prev_ready = sdram_rst ? '0 : cmd_ready_o;
    end

    // sdram_ctrl model: checks each new access against the queue and acks after a random delay.
    always @(posedge sdram_clk) begin
        acc_t e;
        #1;
        sc_ack_i  = 1'b0;
        sc_idle_i = ($urandom_range(0, 3) != 0);
        if (sdram_rst) begin
            in_acc = 1'b0;
        end else begin
            if (sc_acc_o && !in_acc) begin
                in_acc = 1'b1;
                acc_count++;
                ack_delay = $urandom_range(0, 3);
                if (acc_q.size() == 0) begin
                    check("acc_unexpected", 64'(sc_acc_o), 64'd0);
                end else begin
                    e = acc_q.pop_front();
                    check("sc_adr", 64'(sc_adr_o), 64'(e.adr));
                    check("sc_we", 64'(sc_we_o), 64'(e.we));
                    if (e.we) check("sc_dat", 64'(sc_dat_o), 64'(e.dat));
                end
            end
            if (in_acc) begin
                if (acc_count != block_idx) begin
                    if (ack_delay == 0) begin
                        sc_ack_i = 1'b1;
                        in_acc   = 1'b0;
                        if (sc_we_o)
                            sd_mem[int'(sc_adr_o)] = sc_dat_o;
                        else
                            sc_dat_i = sd_mem.exists(int'(sc_adr_o)) ? sd_mem[int'(sc_adr_o)]
                                                                     : init_word(int'(sc_adr_o));
                    end else begin
                        ack_delay--;
                    end
                end
            end else if (!sc_acc_o && $urandom_range(0, 7) == 0) begin
                sc_ack_i = 1'b1;
                sc_dat_i = DW'($urandom);
            end
        end
    end

    always @(posedge sdram_clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready_i = ($urandom_range(0, 2) != 0);
            1:       rsp_ready_i = ~rsp_ready_i;
            default: rsp_ready_i = 1'b1;
        endcase
    end

    // Response monitor: stability under back-pressure and in-order comparison on each handshake.
    logic          prev_stall = 1'b0;
    logic [DW+1:0] prev_bundle = '0;
    always @(negedge sdram_clk) begin
        rsp_t e;
        if (sdram_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("rsp_hold_valid", 64'(rsp_valid_o), 64'd1);
                check("rsp_hold_bundle", 64'({rsp_data_o, rsp_ch_o, rsp_last_o}), 64'(prev_bundle));
            end
            if (rsp_valid_o && rsp_ready_i) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_data", 64'(rsp_data_o), 64'(e.dat));
                    check("rsp_ch", 64'(rsp_ch_o), 64'(e.ch));
                    check("rsp_last", 64'(rsp_last_o), 64'(e.last));
                end
            end
            prev_stall  = rsp_valid_o && !rsp_ready_i;
            prev_bundle = {rsp_data_o, rsp_ch_o, rsp_last_o};
        end
    end

    task automatic check_zero_outputs(input string name);
        check(name, 64'({cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_ch_o, rsp_last_o,
                         sc_acc_o, sc_we_o, sc_adr_o, sc_dat_o}), 64'd0);
    endtask

    task automatic send(input int ch, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [LW-1:0] len, input int give_up);
        int waited;
        waited = 0;
        @(posedge sdram_clk);
        #1;
        cmd_we_i[ch]    = we;
        cmd_addr_i[ch]  = a;
        cmd_data_i[ch]  = d;
        cmd_len_i[ch]   = len;
        cmd_valid_i[ch] = 1'b1;
        forever begin
            @(negedge sdram_clk);
            if (cmd_ready_o[ch]) break;
            waited++;
            if (give_up > 0 && waited >= give_up) break;
            if (waited > 3000) begin
                check("cmd_accept_timeout", 64'(cmd_ready_o[ch]), 64'd1);
                break;
            end
        end
        @(posedge sdram_clk);
        #1;
        cmd_valid_i[ch] = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((acc_q.size() != 0 || rsp_q.size() != 0 || rsp_valid_o || sc_acc_o) && waited < 3000) begin
            @(negedge sdram_clk);
            waited++;
        end
        check("drain", 64'(acc_q.size() + rsp_q.size()), 64'd0);
    endtask

    task automatic rand_channel(input int ch, input int count);
        for (int k = 0; k < count; k++) begin
            logic [AW-1:0] a;
            repeat ($urandom_range(0, 4)) @(posedge sdram_clk);
            a = ($urandom_range(0, 3) == 0) ? AW'(24'hFFFFF8 + $urandom_range(0, 7))
                                            : AW'($urandom_range(0, 31));
            send(ch, 1'($urandom_range(0, 1)), a, DW'($urandom), LW'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
    endtask

    task automatic reset_mid_burst();
        int waited;
        waited = 0;
        block_idx = acc_count + 3;
        send(0, 1'b0, 24'h000200, '0, LW'(8), 0);
        while (!(acc_count == block_idx && sc_acc_o) && waited < 500) begin
            @(negedge sdram_clk);
            waited++;
        end
        check("reach_word3", 64'(acc_count), 64'(block_idx));
        sdram_rst = 1'b1;
        @(negedge sdram_clk);
        check_zero_outputs("rst_mid_burst_outputs");
        acc_q.delete();
        rsp_q.delete();
        ref_ptr   = 0;
        block_idx = -1;
        sdram_rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sdram_rst   = 1'b1;
        cmd_valid_i = '0;
        cmd_we_i    = '0;
        cmd_addr_i  = '0;
        cmd_data_i  = '0;
        cmd_len_i   = '0;
        rsp_ready_i = 1'b0;
        sc_idle_i   = 1'b1;
        sc_dat_i    = '0;
        sc_ack_i    = 1'b0;
        repeat (3) @(negedge sdram_clk);
        check_zero_outputs("reset_outputs");
        sdram_rst = 1'b0;

        // Write then read back the same word on channel 0.
        send(0, 1'b1, 24'h000010, 16'hBEEF, '0, 0);
        send(0, 1'b0, 24'h000010, '0, LW'(1), 0);
        drain();

        // Eight-word read wrapping the top of the address space under toggling back-pressure.
        rdy_mode = 1;
        send(1, 1'b0, 24'hFFFFFC, '0, LW'(8), 0);
        drain();
        rdy_mode = 0;

        // Both channels continuously requesting writes.
        fork
            for (int k = 0; k < 4; k++) send(0, 1'b1, AW'(32 + k), DW'($urandom), '0, 0);
            for (int k = 0; k < 4; k++) send(1, 1'b1, AW'(48 + k), DW'($urandom), '0, 0);
        join
        drain();

        // Out-of-range lengths collapse to one word.
        send(0, 1'b0, 24'h000020, '0, LW'(0), 0);
        send(1, 1'b0, 24'h000030, '0, LW'(12), 0);
        drain();

        reset_mid_burst();
        send(1, 1'b0, 24'h000010, '0, LW'(2), 0);
        drain();

        fork
            rand_channel(0, 30);
            rand_channel(1, 30);
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
